dcache_store_buf: RTL and testbench
===================================

DCACHE_STORE_BUF -- requirements
Module: dcache_store_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16), number of buffered store entries.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have upstream request ports: req_valid in 1; req_op in 1 (0 read, 1 write); req_addr in 32; req_uncached in 1; req_strb in 4; req_wdata in 32.
REQ-005 SHALL have upstream outputs: req_ready out 1; rsp_rvalid out 1 (read data strobe); rsp_rdata out 32; buf_empty out 1.
REQ-006 SHALL have dcache outputs: dc_valid, dc_op, dc_addr[31:0], dc_uncached, dc_strb[3:0], dc_wdata[31:0].
REQ-007 SHALL have dcache inputs: dc_ready in 1 (request taken); dc_rvalid in 1; dc_rdata in 32.

Function
REQ-008 SHALL accept a request on a cycle with req_valid & req_ready.
REQ-009 SHALL buffer accepted writes in a DEPTH-entry FIFO {addr, uncached, strb, wdata}; req_ready for writes = (state==IDLE) & ~full.
REQ-010 SHALL not enqueue when full, even if a dequeue occurs that cycle.
REQ-011 SHALL use wrap-around head/tail pointers with a count of width log2(DEPTH)+1; full = (count==DEPTH), empty = (count==0).
REQ-012 SHALL assert buf_empty = empty, registered state only.
REQ-013 SHALL accept reads only in IDLE (req_ready=1 for reads in IDLE, else 0); one read outstanding maximum.
REQ-014 SHALL implement states IDLE, RD_DRAIN, RD_REQ, RD_WAIT, RD_FWD.
REQ-015 IDLE: read accepted -> RD_FWD if forwarding hit (REQ-028), else RD_REQ if read may bypass (REQ-028/029), else RD_DRAIN; reads are captured into an internal read register.
REQ-016 RD_DRAIN: continue draining; -> RD_REQ on the cycle count reaches 0.
REQ-017 RD_REQ: dc_valid=1, dc_op=0, fields from read register, dc_strb=0; dc_ready & dc_rvalid -> IDLE with rsp pulse; dc_ready & ~dc_rvalid -> RD_WAIT.
REQ-018 RD_WAIT: dc_valid=0; dc_rvalid -> IDLE with rsp pulse.
REQ-019 RD_FWD: one cycle, rsp pulse with forwarded data, -> IDLE; no dcache access.
REQ-020 rsp pulse SHALL be rsp_rvalid=1 for exactly one cycle with rsp_rdata registered from dc_rdata or forwarded data; rsp_rdata holds its value otherwise.
REQ-021 Drain: in IDLE and RD_DRAIN with count>0, SHALL present head entry with dc_valid=1, dc_op=1; dequeue on dc_ready.
REQ-022 No drain writes SHALL be issued in RD_REQ, RD_WAIT or RD_FWD.
REQ-023 dc_valid SHALL be asserted no earlier than the cycle after enqueue; presented fields SHALL stay stable until dc_ready.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order.
REQ-025 Writes SHALL reach dcache strictly in acceptance order.
REQ-026 All dc_* outputs SHALL be 0 when dc_valid=0.

Reset
REQ-027 On reset low at a clock edge SHALL clear head, tail and count, set state IDLE, and set dc_valid=0, rsp_rvalid=0, rsp_rdata=0, req_ready=0; buffered entries and an in-flight read are discarded, and a dc_rvalid arriving after reset is ignored.

Configuration
REQ-028 With STBUF_FWD_EN defined, a cached read SHALL use the youngest buffered entry whose addr[31:2] matches: if that entry is cached and has strb==4'b1111, forward its wdata (RD_FWD); if it is any other match, use RD_DRAIN; if there is no match, go to RD_REQ, bypassing older stores.
REQ-029 Without STBUF_FWD_EN, every read SHALL go to RD_DRAIN when count>0, and to RD_REQ otherwise; no comparators SHALL be synthesised.
REQ-030 Uncached reads SHALL always wait for an empty buffer, in both configurations.

Verification
REQ-031 Bench SHALL cover: 4 writes at 0x1000..0x100C with dc_ready=1 -> 4 dc write beats in order, then buf_empty=1.
REQ-032 Bench SHALL cover: 5 writes with dc_ready=0 -> req_ready=0 after the 4th; 5th accepted the cycle after the first dc_ready.
REQ-033 Bench SHALL cover: write 0x2000 strb 1111 data 0xDEADBEEF, then read 0x2000, dc_ready=0 -> with STBUF_FWD_EN, rsp_rdata=0xDEADBEEF, no dc read; without it, drain then dc read.
REQ-034 Bench SHALL cover: write 0x3000 strb 0001, then read 0x3000 -> drain first, then dc read; rsp_rdata=dc_rdata.
REQ-035 Bench SHALL cover: read with dc_ready=1, dc_rvalid delayed 3 cycles -> RD_WAIT; single rsp_rvalid pulse; no drain during the wait.
REQ-036 Bench SHALL cover: reset low with 2 entries buffered and a read in RD_WAIT -> next cycle count=0, dc_valid=0, rsp_rvalid=0, and a late dc_rvalid produces no response.

Source files
------------

// File: rtl/dcache_store_buf.sv
// dcache_store_buf: write store buffer between the core and the dcache
// Optional feature macro: STBUF_FWD_EN (store-to-load forwarding and read bypass).
// Ports:
//   clk, reset        single clock, synchronous active-low reset
//   req_*             upstream request (op 0 read, 1 write), accepted on req_valid & req_ready
//   rsp_rvalid/rdata  one-cycle read response pulse, rsp_rdata holds between pulses
//   buf_empty         no buffered writes
//   dc_*              dcache request (dc_ready = taken) and read return (dc_rvalid/dc_rdata)
module dcache_store_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_addr,
    input  logic        req_uncached,
    input  logic [3:0]  req_strb,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_rvalid,
    output logic [31:0] rsp_rdata,
    output logic        buf_empty,
    output logic        dc_valid,
    output logic        dc_op,
    output logic [31:0] dc_addr,
    output logic        dc_uncached,
    output logic [3:0]  dc_strb,
    output logic [31:0] dc_wdata,
    input  logic        dc_ready,
    input  logic        dc_rvalid,
    input  logic [31:0] dc_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, RD_DRAIN, RD_REQ, RD_WAIT, RD_FWD} state_t;
    state_t state, state_nxt, rd_target;

    logic [31:0]   q_addr  [DEPTH];
    logic          q_unc   [DEPTH];
    logic [3:0]    q_strb  [DEPTH];
    logic [31:0]   q_wdata [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic          full, empty, drain, rd_req, enq, deq, rd_acc, rsp_fire;
    logic [31:0]   rd_addr, rsp_src;
    logic          rd_unc;

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign buf_empty = empty;
    // Outputs that drive handshakes are held low while reset is asserted.
    assign req_ready = reset && state == IDLE && (!req_op || !full);
    assign enq       = req_valid && req_ready && req_op;
    assign rd_acc    = req_valid && req_ready && !req_op;
    assign drain     = reset && (state == IDLE || state == RD_DRAIN) && !empty;
    assign rd_req    = reset && state == RD_REQ;
    assign deq       = drain && dc_ready;
    assign count_nxt = count + CW'(enq) - CW'(deq);

    assign dc_valid    = drain || rd_req;
    assign dc_op       = drain;
    assign dc_addr     = drain ? q_addr[head] : rd_req ? rd_addr : '0;
    assign dc_uncached = drain ? q_unc[head] : rd_req ? rd_unc : 1'b0;
    assign dc_strb     = drain ? q_strb[head] : '0;
    assign dc_wdata    = drain ? q_wdata[head] : '0;

    assign rsp_fire = state == RD_FWD || (state == RD_REQ && dc_ready && dc_rvalid) ||
                      (state == RD_WAIT && dc_rvalid);

`ifdef STBUF_FWD_EN
    logic          fwd_hit, fwd_full;
    logic [AW-1:0] fwd_idx;
    logic [31:0]   fwd_data;

    // Scan oldest to youngest so the last match wins (youngest store).
    always_comb begin
        fwd_hit = 1'b0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && q_addr[head + AW'(i)][31:2] == req_addr[31:2]) begin
                fwd_hit = 1'b1;
                fwd_idx = head + AW'(i);
            end
        end
    end

    assign fwd_full  = fwd_hit && !q_unc[fwd_idx] && q_strb[fwd_idx] == 4'hF;
    assign rd_target = req_uncached ? (empty ? RD_REQ : RD_DRAIN) :
                       fwd_hit ? (fwd_full ? RD_FWD : RD_DRAIN) : RD_REQ;
    assign rsp_src   = state == RD_FWD ? fwd_data : dc_rdata;

    always_ff @(posedge clk) begin
        if (!reset)
            fwd_data <= '0;
        else if (rd_acc)
            fwd_data <= q_wdata[fwd_idx];
    end
`else
    assign rd_target = empty ? RD_REQ : RD_DRAIN;
    assign rsp_src   = dc_rdata;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rd_acc) state_nxt = rd_target;
            RD_DRAIN: if (count_nxt == '0) state_nxt = RD_REQ;
            RD_REQ:   if (dc_ready) state_nxt = dc_rvalid ? IDLE : RD_WAIT;
            RD_WAIT:  if (dc_rvalid) state_nxt = IDLE;
            RD_FWD:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rd_addr    <= '0;
            rd_unc     <= 1'b0;
            rsp_rvalid <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            rsp_rvalid <= rsp_fire;
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            if (rd_acc) begin
                rd_addr <= req_addr;
                rd_unc  <= req_uncached;
            end
            if (rsp_fire) rsp_rdata <= rsp_src;
        end
    end

    // Entry storage needs no reset: validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[tail]  <= req_addr;
            q_unc[tail]   <= req_uncached;
            q_strb[tail]  <= req_strb;
            q_wdata[tail] <= req_wdata;
        end
    end
endmodule

// File: tb/tb_dcache_store_buf.sv
// tb_dcache_store_buf: directed self-checking bench for dcache_store_buf
module tb_dcache_store_buf;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_op, req_uncached;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        req_ready, rsp_rvalid, buf_empty;
    logic [31:0] rsp_rdata;
    logic        dc_valid, dc_op, dc_uncached;
    logic [31:0] dc_addr, dc_wdata;
    logic [3:0]  dc_strb;
    logic        dc_ready, dc_rvalid;
    logic [31:0] dc_rdata;
    int vectors = 0;
    int miscompares = 0;

    dcache_store_buf #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_uncached(req_uncached), .req_strb(req_strb), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_rvalid(rsp_rvalid), .rsp_rdata(rsp_rdata),
        .buf_empty(buf_empty),
        .dc_valid(dc_valid), .dc_op(dc_op), .dc_addr(dc_addr),
        .dc_uncached(dc_uncached), .dc_strb(dc_strb), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req;
        req_valid = 0; req_op = 0; req_addr = '0; req_uncached = 0; req_strb = '0; req_wdata = '0;
    endtask

    task automatic put_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req_valid = 1; req_op = 1; req_addr = a; req_uncached = 0; req_strb = s; req_wdata = d;
    endtask

    task automatic put_rd(input logic [31:0] a, input logic u);
        req_valid = 1; req_op = 0; req_addr = a; req_uncached = u; req_strb = '0; req_wdata = '0;
    endtask

    task automatic test_reset;
        clr_req;
        dc_ready = 0; dc_rvalid = 0; dc_rdata = '0;
        reset = 0;
        repeat (2) cyc;
        vectors++;
        if (buf_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", buf_empty); end
        vectors++;
        if (dc_valid !== 1'b0 || dc_addr !== 32'h0) begin miscompares++; $display("FAIL reset_dc got valid %b addr %h exp 0 0", dc_valid, dc_addr); end
        vectors++;
        if (rsp_rvalid !== 1'b0 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp got %b %h exp 0 0", rsp_rvalid, rsp_rdata); end
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", req_ready); end
        reset = 1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got %b exp 1", req_ready); end
        cyc;
    endtask

    task automatic test_in_order;
        int n = 0;
        int k = 0;
        dc_ready = 1;
        for (int c = 0; c < 10; c++) begin
            if (k < 4) put_wr(32'h1000 + 32'(4 * k), 4'hF, 32'hA0 + 32'(k)); else clr_req;
            #1;
            if (c == 0) begin
                vectors++;
                if (dc_valid !== 1'b0) begin miscompares++; $display("FAIL enq_same_cycle_valid got %b exp 0", dc_valid); end
            end
            if (dc_valid && dc_ready) begin
                vectors++;
                if (dc_op !== 1'b1 || dc_addr !== 32'h1000 + 32'(4 * n) || dc_wdata !== 32'hA0 + 32'(n))
                begin miscompares++; $display("FAIL order_beat%0d got op %b addr %h data %h exp 1 %h %h", n, dc_op, dc_addr, dc_wdata, 32'h1000 + 32'(4 * n), 32'hA0 + 32'(n)); end
                n++;
            end
            if (req_valid && req_ready) k++;
            cyc;
        end
        vectors++;
        if (n != 4 || k != 4) begin miscompares++; $display("FAIL order_count got beats %0d accepted %0d exp 4 4", n, k); end
        vectors++;
        if (buf_empty !== 1'b1) begin miscompares++; $display("FAIL order_empty got %b exp 1", buf_empty); end
    endtask

    task automatic test_full;
        int n = 2;
        dc_ready = 0;
        for (int k = 0; k < 4; k++) begin
            put_wr(32'h4000 + 32'(4 * k), 4'hF, 32'hB0 + 32'(k));
            #1;
            vectors++;
            if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready%0d got %b exp 1", k, req_ready); end
            cyc;
        end
        put_wr(32'h4010, 4'hF, 32'hB4);
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b exp 0", req_ready); end
        vectors++;
        if (dc_valid !== 1'b1 || dc_addr !== 32'h4000) begin miscompares++; $display("FAIL full_head got %b %h exp 1 4000", dc_valid, dc_addr); end
        cyc;
        dc_ready = 1;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_deq_ready got %b exp 0", req_ready); end
        cyc;
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fifth_accept got %b exp 1", req_ready); end
        vectors++;
        if (dc_addr !== 32'h4004) begin miscompares++; $display("FAIL full_second_head got %h exp 4004", dc_addr); end
        cyc;
        clr_req;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (dc_valid && dc_ready) begin
                vectors++;
                if (dc_addr !== 32'h4000 + 32'(4 * n) || dc_wdata !== 32'hB0 + 32'(n))
                begin miscompares++; $display("FAIL full_beat%0d got %h %h exp %h %h", n, dc_addr, dc_wdata, 32'h4000 + 32'(4 * n), 32'hB0 + 32'(n)); end
                n++;
            end
            cyc;
        end
        vectors++;
        if (n != 5 || buf_empty !== 1'b1) begin miscompares++; $display("FAIL full_drain got beats %0d empty %b exp 5 1", n, buf_empty); end
        dc_ready = 0;
    endtask

    task automatic test_fwd;
        dc_ready = 0;
        put_wr(32'h2000, 4'hF, 32'hDEADBEEF);
        cyc;
        put_rd(32'h2000, 0);
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fwd_rd_ready got %b exp 1", req_ready); end
        cyc;
        clr_req;
        #1;
`ifdef STBUF_FWD_EN
        vectors++;
        if (dc_valid !== 1'b0) begin miscompares++; $display("FAIL fwd_no_dc got %b exp 0", dc_valid); end
        cyc;
        vectors++;
        if (rsp_rvalid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fwd_rsp got %b %h exp 1 deadbeef", rsp_rvalid, rsp_rdata); end
        dc_ready = 1;
        #1;
        vectors++;
        if (dc_valid !== 1'b1 || dc_op !== 1'b1 || dc_addr !== 32'h2000) begin miscompares++; $display("FAIL fwd_later_drain got %b %b %h exp 1 1 2000", dc_valid, dc_op, dc_addr); end
        cyc;
        dc_ready = 0;
        vectors++;
        if (buf_empty !== 1'b1 || rsp_rvalid !== 1'b0) begin miscompares++; $display("FAIL fwd_end got empty %b rvalid %b exp 1 0", buf_empty, rsp_rvalid); end
`else
        vectors++;
        if (dc_valid !== 1'b1 || dc_op !== 1'b1 || dc_addr !== 32'h2000) begin miscompares++; $display("FAIL fwd_drain_first got %b %b %h exp 1 1 2000", dc_valid, dc_op, dc_addr); end
        dc_ready = 1;
        cyc;
        vectors++;
        if (dc_valid !== 1'b1 || dc_op !== 1'b0 || dc_addr !== 32'h2000 || dc_strb !== 4'h0 || dc_wdata !== 32'h0)
        begin miscompares++; $display("FAIL fwd_dc_read got %b %b %h %h %h exp 1 0 2000 0 0", dc_valid, dc_op, dc_addr, dc_strb, dc_wdata); end
        vectors++;
        if (buf_empty !== 1'b1) begin miscompares++; $display("FAIL fwd_drained got %b exp 1", buf_empty); end
        dc_rvalid = 1; dc_rdata = 32'h12345678;
        cyc;
        dc_rvalid = 0; dc_ready = 0;
        vectors++;
        if (rsp_rvalid !== 1'b1 || rsp_rdata !== 32'h12345678) begin miscompares++; $display("FAIL fwd_rsp got %b %h exp 1 12345678", rsp_rvalid, rsp_rdata); end
        cyc;
        vectors++;
        if (rsp_rvalid !== 1'b0 || rsp_rdata !== 32'h12345678) begin miscompares++; $display("FAIL fwd_rsp_hold got %b %h exp 0 12345678", rsp_rvalid, rsp_rdata); end
`endif
    endtask

    task automatic test_partial;
        dc_ready = 0;
        put_wr(32'h3000, 4'h1, 32'h55);
        cyc;
        put_rd(32'h3000, 0);
        cyc;
        clr_req;
        #1;
        vectors++;
        if (dc_valid !== 1'b1 || dc_op !== 1'b1 || dc_addr !== 32'h3000 || dc_strb !== 4'h1)
        begin miscompares++; $display("FAIL part_drain got %b %b %h %h exp 1 1 3000 1", dc_valid, dc_op, dc_addr, dc_strb); end
        dc_ready = 1;
        cyc;
        vectors++;
        if (dc_valid !== 1'b1 || dc_op !== 1'b0 || dc_addr !== 32'h3000 || dc_strb !== 4'h0)
        begin miscompares++; $display("FAIL part_dc_read got %b %b %h %h exp 1 0 3000 0", dc_valid, dc_op, dc_addr, dc_strb); end
        dc_rvalid = 1; dc_rdata = 32'hCAFEF00D;
        cyc;
        dc_rvalid = 0; dc_ready = 0;
        vectors++;
        if (rsp_rvalid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL part_rsp got %b %h exp 1 cafef00d", rsp_rvalid, rsp_rdata); end
        cyc;
        vectors++;
        if (rsp_rvalid !== 1'b0) begin miscompares++; $display("FAIL part_rsp_pulse got %b exp 0", rsp_rvalid); end
    endtask

    task automatic test_wait;
        put_rd(32'h5000, 0);
        dc_ready = 1;
        cyc;
        clr_req;
        #1;
        vectors++;
        if (dc_valid !== 1'b1 || dc_op !== 1'b0 || dc_addr !== 32'h5000) begin miscompares++; $display("FAIL wait_req got %b %b %h exp 1 0 5000", dc_valid, dc_op, dc_addr); end
        cyc;
        for (int w = 0; w < 3; w++) begin
            #1;
            vectors++;
            if (dc_valid !== 1'b0 || rsp_rvalid !== 1'b0 || req_ready !== 1'b0)
            begin miscompares++; $display("FAIL wait_cycle%0d got valid %b rvalid %b ready %b exp 0 0 0", w, dc_valid, rsp_rvalid, req_ready); end
            if (w == 2) begin dc_rvalid = 1; dc_rdata = 32'h0BADCAFE; end
            cyc;
        end
        dc_rvalid = 0;
        vectors++;
        if (rsp_rvalid !== 1'b1 || rsp_rdata !== 32'h0BADCAFE) begin miscompares++; $display("FAIL wait_rsp got %b %h exp 1 0badcafe", rsp_rvalid, rsp_rdata); end
        cyc;
        vectors++;
        if (rsp_rvalid !== 1'b0) begin miscompares++; $display("FAIL wait_single_pulse got %b exp 0", rsp_rvalid); end
        dc_ready = 0;
    endtask

    task automatic test_reset_midflight;
        dc_ready = 0;
        put_wr(32'h6000, 4'hF, 32'h1);
        cyc;
        put_wr(32'h6004, 4'hF, 32'h2);
        cyc;
`ifdef STBUF_FWD_EN
        put_rd(32'h7000, 0);
        cyc;
        clr_req;
        #1;
        vectors++;
        if (dc_valid !== 1'b1 || dc_op !== 1'b0 || dc_addr !== 32'h7000) begin miscompares++; $display("FAIL mid_bypass got %b %b %h exp 1 0 7000", dc_valid, dc_op, dc_addr); end
        dc_ready = 1;
        cyc;
        dc_ready = 0;
        vectors++;
        if (dc_valid !== 1'b0 || buf_empty !== 1'b0) begin miscompares++; $display("FAIL mid_wait got valid %b empty %b exp 0 0", dc_valid, buf_empty); end
`else
        put_rd(32'h6000, 0);
        cyc;
        clr_req;
        #1;
        vectors++;
        if (dc_valid !== 1'b1 || dc_op !== 1'b1 || dc_addr !== 32'h6000) begin miscompares++; $display("FAIL mid_pending got %b %b %h exp 1 1 6000", dc_valid, dc_op, dc_addr); end
`endif
        reset = 0;
        #1;
        vectors++;
        if (req_ready !== 1'b0 || dc_valid !== 1'b0) begin miscompares++; $display("FAIL mid_in_reset got ready %b valid %b exp 0 0", req_ready, dc_valid); end
        cyc;
        vectors++;
        if (buf_empty !== 1'b1 || dc_valid !== 1'b0 || rsp_rvalid !== 1'b0 || rsp_rdata !== 32'h0)
        begin miscompares++; $display("FAIL mid_after_reset got empty %b valid %b rvalid %b rdata %h exp 1 0 0 0", buf_empty, dc_valid, rsp_rvalid, rsp_rdata); end
        reset = 1;
        dc_ready = 1; dc_rvalid = 1; dc_rdata = 32'hFFFF0000;
        cyc;
        dc_rvalid = 0;
        vectors++;
        if (rsp_rvalid !== 1'b0 || dc_valid !== 1'b0) begin miscompares++; $display("FAIL mid_late_rvalid got rvalid %b valid %b exp 0 0", rsp_rvalid, dc_valid); end
        cyc;
        vectors++;
        if (rsp_rvalid !== 1'b0 || rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL mid_no_rsp got %b %h exp 0 0", rsp_rvalid, rsp_rdata); end
        dc_ready = 0;
    endtask

    initial begin
        test_reset;
        test_in_order;
        test_full;
        test_fwd;
        test_partial;
        test_wait;
        test_reset_midflight;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
